// File: rtl/pipe_stage.sv
// Pipeline register stage with optional two-entry skid buffer, flush and stall.
// Entries leave in acceptance order; flush and reset drop held entries without release.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module pipe_stage #(
  parameter int DATA_W = 96,
  parameter int PC_W   = `PC_WIDTH,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_rd_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_rd_we,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [PC_W-1:0]   main_pc;
  logic [DATA_W-1:0] main_data;
  logic              main_rd_we;

  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic              skid_rd_we;

  logic in_fire;
  logic out_fire;

  // With the skid buffer, in_ready comes straight from a flop so the upstream
  // timing path never sees out_ready or stall.
  always_comb begin
    in_ready = 1'b0;
    if (SKID) begin
      in_ready = ~skid_valid;
    end else begin
      in_ready = ~main_valid | (out_ready & ~stall);
    end
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready & ~stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_pc    <= '0;
      main_data  <= '0;
      main_rd_we <= 1'b0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_data  <= '0;
      skid_rd_we <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      // Main is free this cycle: refill from skid first to keep ordering.
      if (SKID && skid_valid) begin
        main_pc    <= skid_pc;
        main_data  <= skid_data;
        main_rd_we <= skid_rd_we;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_pc    <= in_pc;
        main_data  <= in_data;
        main_rd_we <= in_rd_we;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (SKID && in_fire) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_data  <= in_data;
      skid_rd_we <= in_rd_we;
    end
  end

  assign out_valid = main_valid;
  assign out_pc    = main_pc;
  assign out_data  = main_data;
  assign out_rd_we = main_rd_we & main_valid;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: skid (SKID=1) instance with directed vectors,
// plus a single-entry (SKID=0) instance under random handshakes.
module tb_pipe_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [95:0] data;
    logic        we;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // skid instance
  logic        flush = 0, stall = 0, in_valid = 0, in_rd_we = 0, out_ready = 0;
  logic [31:0] in_pc = '0;
  logic [95:0] in_data = '0;
  logic        in_ready, out_valid, out_rd_we;
  logic [31:0] out_pc;
  logic [95:0] out_data;
  logic [1:0]  occupancy;

  // single-entry instance
  logic        z_flush = 0, z_stall = 0, z_in_valid = 0, z_in_rd_we = 0, z_out_ready = 0;
  logic [31:0] z_in_pc = '0;
  logic [95:0] z_in_data = '0;
  logic        z_in_ready, z_out_valid, z_out_rd_we;
  logic [31:0] z_out_pc;
  logic [95:0] z_out_data;
  logic [1:0]  z_occupancy;

  pipe_stage #(.DATA_W(96), .PC_W(32), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .in_rd_we(in_rd_we), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_data(out_data), .out_rd_we(out_rd_we), .occupancy(occupancy)
  );

  pipe_stage #(.DATA_W(96), .PC_W(32), .SKID(1'b0)) dut_z (
    .clk(clk), .rst(rst), .flush(z_flush), .stall(z_stall),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_pc(z_in_pc), .in_data(z_in_data),
    .in_rd_we(z_in_rd_we), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_pc(z_out_pc), .out_data(z_out_data), .out_rd_we(z_out_rd_we), .occupancy(z_occupancy)
  );

  int checks = 0;
  int failures = 0;
  item_t q1[$];
  item_t q0[$];

  function automatic logic [95:0] mk_data(input logic [31:0] pc);
    return {pc ^ 32'hDEAD_BEEF, ~pc, pc};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitors: pop on every release and compare against the oldest accepted entry
  always @(negedge clk) begin
    item_t e;
    if (rst && !flush && out_valid && out_ready && !stall) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL s1_unexpected_release actual_pc=%0h expected=none", out_pc);
      end else begin
        e = q1.pop_front();
        check("s1_pc", out_pc, e.pc);
        check("s1_data", out_data, e.data);
        check("s1_rd_we", out_rd_we, e.we);
      end
    end
    if (!out_valid) check("s1_bubble_we", out_rd_we, 0);
  end

  always @(negedge clk) begin
    item_t e;
    if (rst && z_out_valid && z_out_ready) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL s0_unexpected_release actual_pc=%0h expected=none", z_out_pc);
      end else begin
        e = q0.pop_front();
        check("s0_pc", z_out_pc, e.pc);
        check("s0_data", z_out_data, e.data);
        check("s0_rd_we", z_out_rd_we, e.we);
      end
    end
  end

  // one cycle of stimulus on the skid instance; returns at the following negedge
  task automatic drive1(input logic v, input logic [31:0] pc, input logic we,
                        input logic ordy, input logic stl, input logic fl, input logic r);
    item_t it;
    @(posedge clk); #1;
    in_valid = v; in_pc = pc; in_data = mk_data(pc); in_rd_we = we;
    out_ready = ordy; stall = stl; flush = fl; rst = r;
    @(negedge clk);
    if (!r || fl) begin
      q1.delete();
    end else if (v && in_ready) begin
      it.pc = pc; it.data = mk_data(pc); it.we = we;
      q1.push_back(it);
    end
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] pc);
    check({name, "_valid"}, out_valid, v);
    if (v) check({name, "_pc"}, out_pc, pc);
  endtask

  initial begin
    item_t it;
    repeat (2) @(posedge clk);

    // reset state
    drive1(0, 0, 0, 0, 0, 0, 1);
    expect_out("rst", 0, 0);
    check("rst_pc", out_pc, 0);
    check("rst_data", out_data, 0);
    check("rst_we", out_rd_we, 0);
    check("rst_occ", occupancy, 0);
    check("rst_in_ready", in_ready, 1);

    // streaming at full rate
    drive1(1, 32'h10, 1, 1, 0, 0, 1); check("st_rdy0", in_ready, 1); expect_out("st0", 0, 0);
    drive1(1, 32'h14, 0, 1, 0, 0, 1); check("st_rdy1", in_ready, 1); expect_out("st1", 1, 32'h10);
    drive1(1, 32'h18, 1, 1, 0, 0, 1); check("st_rdy2", in_ready, 1); expect_out("st2", 1, 32'h14);
    drive1(0, 0, 0, 1, 0, 0, 1); check("st_rdy3", in_ready, 1); expect_out("st3", 1, 32'h18);
    drive1(0, 0, 0, 1, 0, 0, 1); expect_out("st4", 0, 0);

    // backpressure fills the skid
    drive1(1, 32'h20, 1, 0, 0, 0, 1); check("bp_rdy0", in_ready, 1); expect_out("bp0", 0, 0);
    drive1(1, 32'h24, 0, 0, 0, 0, 1); check("bp_rdy1", in_ready, 1); check("bp_occ1", occupancy, 1);
    expect_out("bp1", 1, 32'h20);
    drive1(1, 32'h28, 1, 0, 0, 0, 1); check("bp_rdy2", in_ready, 0); check("bp_occ2", occupancy, 2);
    expect_out("bp2", 1, 32'h20);
    drive1(0, 0, 0, 1, 0, 0, 1); check("bp_rdy3", in_ready, 0); expect_out("bp3", 1, 32'h20);
    drive1(0, 0, 0, 1, 0, 0, 1); check("bp_rdy4", in_ready, 1); check("bp_occ4", occupancy, 1);
    expect_out("bp4", 1, 32'h24);
    drive1(0, 0, 0, 1, 0, 0, 1); expect_out("bp5", 0, 0); check("bp_occ5", occupancy, 0);

    // stall holds the output entry
    drive1(1, 32'h30, 1, 1, 0, 0, 1); expect_out("sl0", 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive1(0, 0, 0, 1, 1, 0, 1);
      expect_out("sl_hold", 1, 32'h30);
      check("sl_hold_we", out_rd_we, 1);
      check("sl_hold_occ", occupancy, 1);
    end
    drive1(0, 0, 0, 1, 0, 0, 1); expect_out("sl_rel", 1, 32'h30);
    drive1(0, 0, 0, 1, 0, 0, 1); expect_out("sl_after", 0, 0); check("sl_after_occ", occupancy, 0);

    // flush with both entries held and an accept attempt
    drive1(1, 32'h40, 1, 0, 0, 0, 1);
    drive1(1, 32'h44, 1, 0, 0, 0, 1); expect_out("fl0", 1, 32'h40);
    drive1(1, 32'h48, 1, 0, 0, 1, 1); check("fl_occ_pre", occupancy, 2);
    drive1(0, 0, 0, 0, 0, 0, 1);
    expect_out("fl1", 0, 0); check("fl1_we", out_rd_we, 0);
    check("fl1_occ", occupancy, 0); check("fl1_rdy", in_ready, 1);

    // entry accepted in the flush cycle is discarded
    drive1(1, 32'h50, 1, 0, 0, 0, 1);
    drive1(1, 32'h54, 1, 0, 0, 1, 1); expect_out("fd0", 1, 32'h50); check("fd0_rdy", in_ready, 1);
    drive1(0, 0, 0, 1, 0, 0, 1); expect_out("fd1", 0, 0); check("fd1_occ", occupancy, 0);
    check("fd1_rdy", in_ready, 1);
    drive1(0, 0, 0, 1, 0, 0, 1); expect_out("fd2", 0, 0);

    // reset mid-operation with both entries held
    drive1(1, 32'h60, 1, 0, 0, 0, 1);
    drive1(1, 32'h64, 1, 0, 0, 0, 1);
    drive1(0, 0, 0, 0, 0, 0, 0); check("mr_occ_pre", occupancy, 2);
    drive1(0, 0, 0, 0, 0, 0, 1);
    expect_out("mr", 0, 0);
    check("mr_pc", out_pc, 0); check("mr_data", out_data, 0); check("mr_we", out_rd_we, 0);
    check("mr_occ", occupancy, 0); check("mr_rdy", in_ready, 1);
    drive1(1, 32'h70, 1, 1, 0, 0, 1); expect_out("mr_acc0", 0, 0);
    drive1(0, 0, 0, 1, 0, 0, 1); expect_out("mr_acc1", 1, 32'h70);
    drive1(0, 0, 0, 1, 0, 0, 1); expect_out("mr_acc2", 0, 0);

    // single-entry instance under random handshakes
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      z_in_valid  = 1'($urandom_range(0, 1));
      z_out_ready = 1'($urandom_range(0, 1));
      z_in_pc     = 32'h1000 + 32'(i * 4);
      z_in_data   = mk_data(z_in_pc);
      z_in_rd_we  = z_in_pc[2];
      @(negedge clk);
      if (z_out_valid) check("s0_ready_follows", z_in_ready, z_out_ready);
      else check("s0_ready_empty", z_in_ready, 1);
      if (z_in_valid && z_in_ready) begin
        it.pc = z_in_pc; it.data = z_in_data; it.we = z_in_rd_we;
        q0.push_back(it);
      end
    end
    @(posedge clk); #1;
    z_in_valid = 0; z_out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("s1_queue_drained", 32'(q1.size()), 0);
    check("s0_queue_drained", 32'(q0.size()), 0);
    check("s0_final_valid", z_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
